// File: rtl/multi_period_meter_pkg.sv
// Shared constants for the multi-channel period / high-time meter.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Holds the default result width, the default stale timeout, the deglitch
// hold length and the two-bit edge codes formed as {previous level, level}.
// Consumed by multi_period_meter and period_channel via import.

package multi_period_meter_pkg;

    // Default counter / result width in bits.
    localparam int DEF_WIDTH = 32;

    // Default number of cycles without a rising edge before a channel is stale.
    localparam int DEF_TIMEOUT = 100000000;

    // Consecutive cycles the synchronised input must hold a new level before
    // the deglitch filter follows it (only used when DEGLITCH_EN is defined).
    localparam int DEGLITCH_LEN = 4;
    localparam int DEGLITCH_CW  = $clog2(DEGLITCH_LEN);

    // Edge codes, formed as {prev_level, cur_level}.
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;

endpackage

// File: rtl/multi_period_meter_period_channel.sv
// One meter channel: synchroniser, optional deglitch filter, saturating counter, result registers.
// Latency: SYNC_STAGES cycles from d to a registered edge decision, +1 to the result/strobe (+DEGLITCH_LEN with filter).
// Backpressure: none; results are status registers overwritten on every new measurement.
//
// Macro DEGLITCH_EN: when defined, a hold-time filter sits between the
// synchroniser and the edge detector; when undefined the edge detector sees
// the synchroniser output directly.
//
// Ports:
//   clock      in   system clock, posedge
//   reset      in   asynchronous active-low reset
//   d          in   asynchronous pulse input
//   clear      in   synchronous clear of the sticky overflow flag
//   period     out  last rising-to-rising interval in cycles
//   high_time  out  last rising-to-falling interval in cycles
//   new_sample out  one-cycle strobe, period updated this cycle
//   overflow   out  sticky, a measurement saturated since the last clear
//   stale      out  armed channel has seen no rising edge for >= TIMEOUT cycles

module period_channel
    import multi_period_meter_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             d,
    input  logic             clear,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             new_sample,
    output logic             overflow,
    output logic             stale
);

    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

    // ------------------------------------------------------------------
    // Input synchroniser. SYNC_STAGES must be at least 2; the oldest stage
    // is the metastability-settled level s.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Filtered level f seen by the edge detector.
    // ------------------------------------------------------------------
    logic f;

`ifdef DEGLITCH_EN
    // The counter tracks how many consecutive cycles s has disagreed with f.
    // Because s is a single bit, "disagrees for DEGLITCH_LEN cycles in a row"
    // is the same as "held the new level for DEGLITCH_LEN cycles".
    localparam logic [DEGLITCH_CW-1:0] DG_LAST = DEGLITCH_CW'(DEGLITCH_LEN - 1);
    localparam logic [DEGLITCH_CW-1:0] DG_ONE  = DEGLITCH_CW'(1);

    logic                   f_q;
    logic                   f_d;
    logic [DEGLITCH_CW-1:0] dg_cnt_q;
    logic [DEGLITCH_CW-1:0] dg_cnt_d;

    always_comb begin
        f_d      = f_q;
        dg_cnt_d = '0;
        if (s != f_q) begin
            if (dg_cnt_q == DG_LAST) begin
                f_d = s;
            end else begin
                dg_cnt_d = dg_cnt_q + DG_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            f_q      <= 1'b0;
            dg_cnt_q <= '0;
        end else begin
            f_q      <= f_d;
            dg_cnt_q <= dg_cnt_d;
        end
    end

    assign f = f_q;
`else
    assign f = s;
`endif

    // ------------------------------------------------------------------
    // Edge detection, counter and result registers.
    // ------------------------------------------------------------------
    logic             prev_q,   prev_d;
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic             armed_q,  armed_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_q,   high_d;
    logic             strobe_q, strobe_d;
    logic             ovf_q,    ovf_d;
    logic             stale_q,  stale_d;

    logic [1:0]       edge_code;
    logic             cnt_sat;
    logic [WIDTH-1:0] meas;
    logic             ovf_set;

    always_comb begin
        edge_code = {prev_q, f};
        cnt_sat   = (cnt_q == CNT_MAX);
        // The interval ends on this cycle, so it is one more than the count;
        // a saturated counter means the true interval is unknown.
        meas      = cnt_sat ? CNT_MAX : (cnt_q + CNT_ONE);

        prev_d   = f;
        cnt_d    = cnt_sat ? cnt_q : (cnt_q + CNT_ONE);
        armed_d  = armed_q;
        period_d = period_q;
        high_d   = high_q;
        strobe_d = 1'b0;
        stale_d  = stale_q;
        ovf_set  = 1'b0;

        if (edge_code == EDGE_RISE) begin
            cnt_d   = '0;
            armed_d = 1'b1;
            // The first rise after reset has no start point: it only arms.
            if (armed_q) begin
                period_d = meas;
                strobe_d = 1'b1;
                stale_d  = 1'b0;
                ovf_set  = cnt_sat;
            end
        end else begin
            if ((edge_code == EDGE_FALL) && armed_q) begin
                high_d  = meas;
                ovf_set = cnt_sat;
            end
            if (armed_q && (cnt_q >= TIMEOUT_W)) begin
                stale_d = 1'b1;
            end
        end

        // A new saturation in the same cycle as clear must survive.
        ovf_d = (clear ? 1'b0 : ovf_q) | ovf_set;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_q   <= 1'b0;
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            period_q <= '0;
            high_q   <= '0;
            strobe_q <= 1'b0;
            ovf_q    <= 1'b0;
            stale_q  <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            period_q <= period_d;
            high_q   <= high_d;
            strobe_q <= strobe_d;
            ovf_q    <= ovf_d;
            stale_q  <= stale_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign new_sample = strobe_q;
    assign overflow   = ovf_q;
    assign stale      = stale_q;

endmodule

// File: rtl/multi_period_meter.sv
// Multi-channel period and high-time meter for the synchronization block.
// Latency: SYNC_STAGES+1 cycles from an input edge to the result and strobe (+4 with DEGLITCH_EN).
// Backpressure: none; each channel's results are status registers with a one-cycle new-sample strobe.
//
// Macro DEGLITCH_EN: enables a per-channel hold-time filter that ignores
// pulses shorter than 4 cycles (see period_channel).
//
// Ports:
//   clock      in   system clock, posedge
//   reset      in   asynchronous active-low reset
//   d          in   CHANNELS asynchronous pulse inputs, bit i = channel i
//   clear      in   synchronous clear of all sticky overflow flags
//   period     out  CHANNELS*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   high_time  out  CHANNELS*WIDTH, same packing
//   new_sample out  CHANNELS one-cycle strobes
//   overflow   out  CHANNELS sticky saturation flags
//   stale      out  CHANNELS no-rising-edge-for-TIMEOUT flags

module multi_period_meter
    import multi_period_meter_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       d,
    input  logic                      clear,
    output logic [CHANNELS*WIDTH-1:0] period,
    output logic [CHANNELS*WIDTH-1:0] high_time,
    output logic [CHANNELS-1:0]       new_sample,
    output logic [CHANNELS-1:0]       overflow,
    output logic [CHANNELS-1:0]       stale
);

    // Channels share nothing but clock, reset and clear, so simultaneous
    // edges on any set of channels are handled in the same cycle.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        period_channel #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES),
            .TIMEOUT     (TIMEOUT)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .d          (d[i]),
            .clear      (clear),
            .period     (period[i*WIDTH +: WIDTH]),
            .high_time  (high_time[i*WIDTH +: WIDTH]),
            .new_sample (new_sample[i]),
            .overflow   (overflow[i]),
            .stale      (stale[i])
        );
    end

endmodule
